// File: rtl/hamming_uart_receiver_if.sv
// hamming_uart_receiver_if: serial input and decoded-byte outputs of the Hamming UART receiver
interface hamming_uart_receiver_if;
  logic rx_i;
  logic [7:0] data_o;
  logic valid_o;
  logic corr_o;
  logic uncorr_o;
  logic frame_err_o;
`ifdef HAMMING_RX_STATS_EN
  logic cnt_clr_i;
  logic [7:0] corr_cnt_o;
  logic [7:0] uncorr_cnt_o;
  modport master(input rx_i, cnt_clr_i, output data_o, valid_o, corr_o, uncorr_o, frame_err_o, corr_cnt_o, uncorr_cnt_o);
  modport slave(output rx_i, cnt_clr_i, input data_o, valid_o, corr_o, uncorr_o, frame_err_o, corr_cnt_o, uncorr_cnt_o);
`else
  modport master(input rx_i, output data_o, valid_o, corr_o, uncorr_o, frame_err_o);
  modport slave(output rx_i, input data_o, valid_o, corr_o, uncorr_o, frame_err_o);
`endif
endinterface

// File: rtl/hamming_uart_receiver.sv
// hamming_uart_receiver: 8N1 receiver, two-byte package assembly and SECDED decode; HAMMING_RX_STATS_EN adds saturating corr/uncorr counters
module hamming_uart_receiver #(
  parameter int FREQUENCY = 50_000_000,
  parameter int SPEED = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input logic CLK_i,
  input logic reset_n,
  hamming_uart_receiver_if.master bus
);
  localparam int DIV = FREQUENCY / SPEED;
  localparam int HALF = DIV / 2;
  localparam int TO = TIMEOUT_BITS * DIV;
  localparam int CW = $clog2(DIV + 1);
  localparam int TW = $clog2(TO + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] tick, tick_n;
  logic [TW-1:0] to_cnt;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] sh, sh_n, hi_byte;
  logic [5:0] dh, dl;
  logic rx_s1, rx_s2, rx_prev, fall, have_hi, byte_done, stop_err, timeout;
  // returns {nibble, corrected, uncorrectable}
  function automatic logic [5:0] dec(input logic [7:0] b);
    logic [2:0] s;
    logic p;
    s = {b[4] ^ b[5] ^ b[6] ^ b[7], b[2] ^ b[3] ^ b[6] ^ b[7], b[1] ^ b[3] ^ b[5] ^ b[7]};
    p = ^b;
    return {b[7] ^ (p && s == 3'd7), b[6] ^ (p && s == 3'd6), b[5] ^ (p && s == 3'd5),
            b[3] ^ (p && s == 3'd3), p, (s != 3'd0) & ~p};
  endfunction
  assign fall = rx_prev & ~rx_s2;
  assign dh = dec(hi_byte);
  assign dl = dec(sh);
  assign timeout = have_hi && state == IDLE && !fall && to_cnt == TW'(TO - 1);
  always_comb begin
    state_n = state;
    tick_n = tick + 1'b1;
    bit_n = bit_idx;
    sh_n = sh;
    byte_done = 1'b0;
    stop_err = 1'b0;
    case (state)
      IDLE: begin
        tick_n = '0;
        state_n = fall ? START : IDLE;
      end
      START: if (tick == CW'(HALF - 1)) begin
        tick_n = '0;
        state_n = rx_s2 ? IDLE : DATA;
      end
      DATA: if (tick == CW'(DIV - 1)) begin
        tick_n = '0;
        sh_n = {rx_s2, sh[7:1]};
        bit_n = bit_idx + 1'b1;
        state_n = bit_idx == 3'd7 ? STOP : DATA;
      end
      default: if (tick == CW'(DIV - 1)) begin
        tick_n = '0;
        byte_done = rx_s2;
        stop_err = ~rx_s2;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK_i) begin
    if (reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      state <= IDLE;
      tick <= '0;
      bit_idx <= '0;
      sh <= '0;
      hi_byte <= '0;
      have_hi <= 1'b0;
      to_cnt <= '0;
      bus.data_o <= '0;
      bus.valid_o <= 1'b0;
      bus.corr_o <= 1'b0;
      bus.uncorr_o <= 1'b0;
      bus.frame_err_o <= 1'b0;
    end else begin
      rx_s1 <= bus.rx_i;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      state <= state_n;
      tick <= tick_n;
      bit_idx <= bit_n;
      sh <= sh_n;
      to_cnt <= (have_hi && state == IDLE) ? to_cnt + 1'b1 : '0;
      bus.valid_o <= byte_done & have_hi;
      bus.frame_err_o <= stop_err | timeout;
      if (stop_err || timeout) have_hi <= 1'b0;
      else if (byte_done) have_hi <= ~have_hi;
      if (byte_done && !have_hi) hi_byte <= sh;
      if (byte_done && have_hi) begin
        bus.data_o <= {dh[5:2], dl[5:2]};
        bus.uncorr_o <= dh[0] | dl[0];
        bus.corr_o <= (dh[1] | dl[1]) & ~(dh[0] | dl[0]);
      end
    end
  end
`ifdef HAMMING_RX_STATS_EN
  always_ff @(posedge CLK_i) begin
    if (reset_n || bus.cnt_clr_i) begin
      bus.corr_cnt_o <= '0;
      bus.uncorr_cnt_o <= '0;
    end else begin
      if (bus.valid_o && bus.corr_o && bus.corr_cnt_o != 8'hff) bus.corr_cnt_o <= bus.corr_cnt_o + 1'b1;
      if (bus.valid_o && bus.uncorr_o && bus.uncorr_cnt_o != 8'hff) bus.uncorr_cnt_o <= bus.uncorr_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hamming_uart_receiver.sv
// tb_hamming_uart_receiver: directed vector table, corner sequences and random packages against a nearest-codeword model
module tb_hamming_uart_receiver;
  localparam int DIV = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_fail = 0, fe_cnt = 0, cyc = 0, t0 = 0;
  typedef struct {logic [7:0] d; logic c, u; int at;} ev_t;
  typedef struct {logic [7:0] hi, lo, d; logic c, u;} vec_t;
  ev_t got_q[$];
  vec_t vt[7];
  always #5 clk = ~clk;
  hamming_uart_receiver_if bus();
  hamming_uart_receiver #(.FREQUENCY(160), .SPEED(10), .TIMEOUT_BITS(20)) dut (
    .CLK_i(clk), .reset_n(rst), .bus(bus));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.valid_o) got_q.push_back('{bus.data_o, bus.corr_o, bus.uncorr_o, cyc});
    if (bus.frame_err_o) fe_cnt++;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within 200000 cycles");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask
  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [6:0] r;
    r = {n[3], n[2], n[1], n[1] ^ n[2] ^ n[3], n[0], n[0] ^ n[2] ^ n[3], n[0] ^ n[1] ^ n[3]};
    return {r, ^r};
  endfunction
  // nearest codeword by exhaustive Hamming distance: {nibble, distance}
  function automatic logic [5:0] ref_dec(input logic [7:0] b);
    int best = 9;
    logic [3:0] bn = '0;
    for (int i = 0; i < 16; i++)
      if ($countones(b ^ enc(4'(i))) < best) begin
        best = $countones(b ^ enc(4'(i)));
        bn = 4'(i);
      end
    return {bn, 2'(best)};
  endfunction
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx_i = f[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    bus.rx_i = 1'b1;
  endtask
  task automatic idle(input int bits);
    bus.rx_i = 1'b1;
    repeat (bits * DIV) @(posedge clk);
    #1;
  endtask
  task automatic send_pkg(input logic [7:0] hi, input logic [7:0] lo, input int gap);
    send_byte(hi);
    idle(gap);
    t0 = cyc;
    send_byte(lo);
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic expect_pkg(input string nm, input logic [7:0] d, input logic c, input logic u, input logic lat);
    ev_t e;
    chk({nm, ".count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      e = got_q.pop_front();
      if (!u) chk({nm, ".data"}, e.d, d);
      chk({nm, ".corr"}, e.c, c);
      chk({nm, ".uncorr"}, e.u, u);
      if (lat) chk_rng({nm, ".latency"}, e.at - t0, 152, 158);
    end
    got_q.delete();
  endtask
  initial begin
    logic [7:0] hb, lb, mh, ml;
    logic [5:0] rh, rl;
    logic eu, ec;
    int fe0, k;
`ifdef HAMMING_RX_STATS_EN
    bus.cnt_clr_i = 1'b0;
`endif
    vt[0] = '{8'hA5, 8'h5A, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'hA5, 8'h5E, 8'hA5, 1'b1, 1'b0};
    vt[2] = '{8'hA5, 8'h5B, 8'hA5, 1'b1, 1'b0};
    vt[3] = '{8'hA5, 8'h1E, 8'h00, 1'b0, 1'b1};
    vt[4] = '{8'h00, 8'hFF, 8'h0F, 1'b0, 1'b0};
    vt[5] = '{8'hA4, 8'h5A, 8'hA5, 1'b1, 1'b0};
    vt[6] = '{8'h24, 8'h5A, 8'h00, 1'b0, 1'b1};
    bus.rx_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.data", bus.data_o, 0);
    chk("reset.valid", bus.valid_o, 0);
    chk("reset.corr", bus.corr_o, 0);
    chk("reset.uncorr", bus.uncorr_o, 0);
    chk("reset.frame_err", bus.frame_err_o, 0);
    for (int i = 0; i < 7; i++) begin
      fe0 = fe_cnt;
      send_pkg(vt[i].hi, vt[i].lo, i % 3);
      expect_pkg($sformatf("vec%0d", i), vt[i].d, vt[i].c, vt[i].u, 1'b1);
      chk($sformatf("vec%0d.frame_err", i), fe_cnt - fe0, 0);
      idle(1);
    end
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0);
    idle(1);
    chk("framing.frame_err", fe_cnt - fe0, 1);
    send_pkg(8'hA5, 8'h5A, 0);
    expect_pkg("framing", 8'hA5, 1'b0, 1'b0, 1'b0);
    fe0 = fe_cnt;
    send_byte(8'hA5);
    idle(19);
    chk("timeout.early", fe_cnt - fe0, 0);
    idle(2);
    chk("timeout.fired", fe_cnt - fe0, 1);
    chk("timeout.no_valid", got_q.size(), 0);
    send_pkg(8'hA5, 8'h5A, 1);
    expect_pkg("timeout", 8'hA5, 1'b0, 1'b0, 1'b0);
    fe0 = fe_cnt;
    bus.rx_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(3);
    chk("glitch.valid", got_q.size(), 0);
    chk("glitch.frame_err", fe_cnt - fe0, 0);
    send_byte(8'hA5);
    bus.rx_i = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      bus.rx_i = i[0];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus.rx_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst.data", bus.data_o, 0);
    chk("midrst.corr", bus.corr_o, 0);
    chk("midrst.uncorr", bus.uncorr_o, 0);
    rst = 1'b0;
    fe0 = fe_cnt;
    idle(2);
    chk("midrst.valid", got_q.size(), 0);
    chk("midrst.frame_err", fe_cnt - fe0, 0);
    send_pkg(8'hA5, 8'h5A, 0);
    expect_pkg("after_rst", 8'hA5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      mh = '0;
      ml = '0;
      k = $urandom_range(0, 2);
      while ($countones(mh) < k) mh |= 8'(1 << $urandom_range(0, 7));
      k = $urandom_range(0, 2);
      while ($countones(ml) < k) ml |= 8'(1 << $urandom_range(0, 7));
      hb = enc(4'($urandom_range(0, 15))) ^ mh;
      lb = enc(4'($urandom_range(0, 15))) ^ ml;
      rh = ref_dec(hb);
      rl = ref_dec(lb);
      eu = rh[1:0] == 2'd2 || rl[1:0] == 2'd2;
      ec = !eu && (rh[1:0] == 2'd1 || rl[1:0] == 2'd1);
      fe0 = fe_cnt;
      send_pkg(hb, lb, $urandom_range(0, 4));
      expect_pkg($sformatf("rnd%0d_%02h_%02h", i, hb, lb), {rh[5:2], rl[5:2]}, ec, eu, 1'b1);
      chk($sformatf("rnd%0d.frame_err", i), fe_cnt - fe0, 0);
      idle($urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hamming_uart_receiver.md
Name: hamming_uart_receiver

Overview:
- Receive end of the Hamming-protected UART link: 8N1 serial receiver plus package reassembly and SECDED decode.
- Each payload byte arrives as a 16-bit package sent as two UART bytes, high byte first.
- Each byte is an extended Hamming(8,4) codeword of one nibble. The block outputs the corrected payload byte with corrected/uncorrectable status.
- Sits between the board UART_RXD pin and the consumer logic.

Parameters:
- FREQUENCY, 50_000_000, system clock frequency in Hz.
- SPEED, 9600, baud rate. Bit period Divider = FREQUENCY/SPEED (5208 cycles at defaults).
- TIMEOUT_BITS, 20, idle bit periods allowed between the high byte's stop bit and the low byte's start bit.

Ports:
- CLK_i  in  1  system clock.
- reset_n  in  1  synchronous, active-high reset (port name fixed; high = reset).
- rx_i  in  1  serial line, idle high, asynchronous to CLK_i.
- data_o  out  8  decoded payload byte.
- valid_o  out  1  one-cycle pulse; data_o, corr_o and uncorr_o are valid in this cycle.
- corr_o  out  1  at least one nibble had a single-bit error that was corrected.
- uncorr_o  out  1  at least one nibble had a double error; data_o is undefined in content but still driven.
- frame_err_o  out  1  one-cycle pulse on a bad stop bit or an inter-byte timeout.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; expecting high byte; counters 0. The rx_i synchroniser resets to all 1.
- Input path: rx_i passes through a 2-flop synchroniser. All decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synchronised 1->0 edge, go to START with tick counter cleared.
  - START: after Divider/2 cycles, sample the line.
    - Sample = 0: go to DATA.
    - Sample = 1: glitch; return to IDLE with no error.
  - DATA: sample every Divider cycles, LSB first, 8 bits. Then go to STOP.
  - STOP: sample after Divider cycles.
    - Sample = 1: raise internal byte_done for 1 cycle.
    - Sample = 0: pulse frame_err_o, discard the byte, reset assembly to expect the high byte.
    - Either way, return to IDLE in the next cycle (mid-stop-bit).
- Assembly:
  - First good byte is latched as hi_byte and a timeout counter starts.
  - If TIMEOUT_BITS*Divider cycles pass without a start edge: pulse frame_err_o, drop hi_byte, expect the high byte again.
  - Second good byte forms package {hi_byte, lo_byte}.
- Codeword bit map, per byte: b7=d3, b6=d2, b5=d1, b4=p4, b3=d0, b2=p2, b1=p1, b0=overall parity (even over b7..b0).
- Decode per nibble:
  - Syndrome s = {b4^b5^b6^b7, b2^b3^b6^b7, b1^b3^b5^b7}; P = XOR of all 8 bits.
  - s=0, P=0: clean.
  - s!=0, P=1: flip bit s; corrected.
  - s=0, P=1: b0 in error; data unaffected; corrected.
  - s!=0, P=0: uncorrectable.
- Output mapping: data_o = {nibble(hi_byte), nibble(lo_byte)}. corr_o / uncorr_o = OR over both nibbles. If uncorrectable, corr_o=0.
- Latency: outputs are registered; valid_o asserts exactly 1 cycle after the low byte's byte_done.
- Hold behaviour: data_o/corr_o/uncorr_o hold their values until the next valid_o.
- Reset mid-frame: the partial byte and hi_byte are discarded and no pulses are emitted. The next falling edge after reset release is treated as a start bit.
- Start edge arriving while in STOP is ignored. This is allowed because the FSM returns to IDLE mid-stop-bit, so a back-to-back byte is still caught.

Optional Feature:
- Macro: HAMMING_RX_STATS_EN.
- Defined:
  - Adds outputs corr_cnt_o[7:0] and uncorr_cnt_o[7:0]: saturating counts (stick at 255) of valid_o cycles with corr_o / uncorr_o.
  - Adds input cnt_clr_i: synchronous clear; clear wins over a simultaneous increment.
  - Counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Clean package: serial bytes 0xA5 then 0x5A at 9600 baud -> one valid_o pulse, data_o=0xA5, corr_o=0, uncorr_o=0, 1 cycle after the second stop-bit sample.
- Single error: 0xA5 then 0x5E (bit2 flipped) -> data_o=0xA5, corr_o=1, uncorr_o=0. Repeat with bit0 flipped (0x5B) -> same result.
- Double error: 0xA5 then 0x1E (0x5A^0x44) -> valid_o=1, uncorr_o=1, corr_o=0.
- Framing: 0xA5 with stop bit forced 0, then 0xA5, 0x5A -> frame_err_o pulse, then exactly one valid_o with data_o=0xA5.
- Timeout and glitch:
  - 0xA5, then 21 idle bit periods, then 0xA5, 0x5A -> frame_err_o at 20 bit periods, then data_o=0xA5.
  - A 1000-cycle low glitch -> no output activity.
- Reset mid-frame: assert reset_n during the data bits of the low byte -> no valid_o, all outputs 0. The next full package decodes correctly. With HAMMING_RX_STATS_EN, 300 corrected packages -> corr_cnt_o=255.
